pq_deq_stage: RTL and testbench

- Downstream drain stage for the shift-register priority queue.
- Pops the queue head whenever local buffer space exists and presents entries to a consumer on a valid/ready stream.
- Small in-order output buffer (DEPTH entries) decouples consumer backpressure from the queue's deq timing, which is single-cycle and fire-and-forget.
- Buffered entries leave priority ordering. DEPTH bounds the staleness window.

---
 rtl/pq_deq_stage.sv | 130 +++++++++++++
 tb/tb_pq_deq_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pq_deq_stage.sv
// pq_deq_stage: drain stage for the shift-register priority queue.
// Pops the queue head whenever the local in-order buffer has room (or is
// being drained the same cycle) and presents entries on a valid/ready stream.
// Optional build macro: PQ_DEQ_STATS_EN adds deq_cnt / stall_cnt outputs.

package pq_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
endpackage

module pq_deq_stage #(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int DEPTH     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvo,
  input  logic                           pq_empty,
  output logic                           pq_deq,
  input  logic                           flush,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] m_kv,
  output logic                           m_valid,
  input  logic                           m_ready
`ifdef PQ_DEQ_STATS_EN
  ,
  output logic [15:0]                    deq_cnt,
  output logic [15:0]                    stall_cnt
`endif
);

  localparam int KV_W  = KEY_WIDTH + VAL_WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $fatal(1, "pq_deq_stage: DEPTH=%0d outside legal range 1..4", DEPTH);
    end
  endgenerate

  logic [KV_W-1:0]  r_buf [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_valid;
  logic             w_accept;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Wrap by compare so non-power-of-2 depths cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_valid  = (r_count != '0);
  // A flush cycle ignores the consumer handshake entirely.
  assign w_accept = w_valid && m_ready && !flush;
  // Popping into a full buffer is safe only when the head leaves this same edge.
  assign w_pop    = !pq_empty && !flush &&
                    ((r_count < DEPTH_C) || (w_valid && m_ready));

  assign pq_deq  = w_pop && rst_n;
  assign m_valid = w_valid;
  assign m_kv    = r_buf[r_rd_ptr];

  // Next occupancy from the pop/accept combination.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_pop, w_accept})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer and occupancy registers; flush rewinds everything to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_pop)    r_wr_ptr <= ptr_inc(r_wr_ptr);
      r_count <= w_count_nxt;
    end
  end

  // Entry storage: captures the queue head on the edge it is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_pop) begin
      r_buf[r_wr_ptr] <= pq_kvo;
    end
  end

`ifdef PQ_DEQ_STATS_EN
  logic [15:0] r_deq_cnt;
  logic [15:0] r_stall_cnt;

  // Pop counter wraps; stall counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deq_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_deq_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop) r_deq_cnt <= r_deq_cnt + 16'd1;
      if (w_valid && !m_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign deq_cnt   = r_deq_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pq_deq_stage.sv
// Self-checking bench for pq_deq_stage: directed steps plus a randomized
// phase, all compared against a queue-based reference model.
module tb_pq_deq_stage;
  localparam int KW    = 8;
  localparam int VW    = 8;
  localparam int KV_W  = KW + VW;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [KV_W-1:0] pq_kvo;
  logic            pq_empty;
  logic            pq_deq;
  logic            flush;
  logic [KV_W-1:0] m_kv;
  logic            m_valid;
  logic            m_ready;
`ifdef PQ_DEQ_STATS_EN
  logic [15:0]     deq_cnt;
  logic [15:0]     stall_cnt;
  int              mdl_deq   = 0;
  int              mdl_stall = 0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [KV_W-1:0] upq[$];   // upstream priority queue contents, head first
  logic [KV_W-1:0] mq[$];    // expected buffered entries, stream order

  always #5 clk = ~clk;

  pq_deq_stage #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pq_kvo   (pq_kvo),
    .pq_empty (pq_empty),
    .pq_deq   (pq_deq),
    .flush    (flush),
    .m_kv     (m_kv),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
`ifdef PQ_DEQ_STATS_EN
    ,
    .deq_cnt  (deq_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [KV_W-1:0] kv(input int k, input int v);
    return {KW'(k), VW'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check, model the posedge effects.
  task automatic step(input logic fl, input logic rdy);
    logic exp_deq;
    logic acc;
    flush    = fl;
    m_ready  = rdy;
    pq_empty = (upq.size() == 0);
    pq_kvo   = pq_empty ? KV_W'($urandom) : upq[0];
    #1;
    exp_deq = !pq_empty && !fl &&
              ((mq.size() < DEPTH) || (mq.size() != 0 && rdy));
    acc = (mq.size() != 0) && rdy && !fl;
    chk("pq_deq", 32'(pq_deq), 32'(exp_deq));
    chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("m_kv", 32'(m_kv), 32'(mq[0]));
`ifdef PQ_DEQ_STATS_EN
    chk("deq_cnt", 32'(deq_cnt), 32'(mdl_deq[15:0]));
    chk("stall_cnt", 32'(stall_cnt), 32'(mdl_stall));
`endif
    @(posedge clk);
    if (fl) begin
      mq.delete();
`ifdef PQ_DEQ_STATS_EN
      mdl_deq = 0; mdl_stall = 0;
`endif
    end else begin
`ifdef PQ_DEQ_STATS_EN
      if (exp_deq) mdl_deq++;
      if (mq.size() != 0 && !rdy && mdl_stall < 65535) mdl_stall++;
`endif
      if (acc) void'(mq.pop_front());
      if (exp_deq) begin
        mq.push_back(upq[0]);
        void'(upq.pop_front());
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b1;
    upq.push_back(kv(8, 14));
    pq_empty = 1'b0; pq_kvo = upq[0];
    repeat (2) @(negedge clk);
    // Reset state: no pop even though the queue is non-empty.
    chk("rst_pq_deq", 32'(pq_deq), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_kv", 32'(m_kv), 32'd0);
    rst_n = 1'b1;

    // First cycle after reset pops {8,14}; next cycle it is presented.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Backpressure: exactly DEPTH pops, then four in-order accepts.
    upq.push_back(kv(1, 11)); upq.push_back(kv(9, 10));
    upq.push_back(kv(9, 11)); upq.push_back(kv(9, 12));
    repeat (4) step(1'b0, 1'b0);
    chk("bp_upq_left", 32'(upq.size()), 32'd2);
    repeat (5) step(1'b0, 1'b1);

    // Full buffer with ready held: one pop and one accept every cycle.
    for (int i = 0; i < 8; i++) upq.push_back(KV_W'($urandom));
    repeat (2) step(1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1);
    chk("thru_upq_left", 32'(upq.size()), 32'd0);
    repeat (3) step(1'b0, 1'b1);

    // Flush with a full buffer and a non-empty queue, then resume.
    for (int i = 0; i < 4; i++) upq.push_back(KV_W'($urandom));
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);

    // Asynchronous reset with one entry buffered.
    upq.delete();
    upq.push_back(kv(5, 6));
    step(1'b0, 1'b0);
    upq.push_back(kv(7, 7));
    pq_empty = 1'b0; pq_kvo = upq[0];
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_m_kv", 32'(m_kv), 32'd0);
    chk("arst_pq_deq", 32'(pq_deq), 32'd0);
    mq.delete();
`ifdef PQ_DEQ_STATS_EN
    mdl_deq = 0; mdl_stall = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && upq.size() < 6) upq.push_back(KV_W'($urandom));
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
    end

`ifdef PQ_DEQ_STATS_EN
    // Stall counter saturation.
    upq.push_back(kv(3, 3));
    step(1'b0, 1'b0);
    flush = 1'b0; m_ready = 1'b0; pq_empty = 1'b1;
    repeat (65540) @(negedge clk);
    #1;
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
